// File: rtl/decode_stage.sv
// Registered instruction-decode stage with a 2-entry skid buffer between fetch and register read.
// The decoded bundle is built combinationally from the input and then lands in the main or skid register.
module decode_stage #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LINK_REG   = 31,
  parameter int unsigned ZEXT_LOGIC = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_inst,
  input  logic [DATA_W-1:0] in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [5:0]        opcode,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [4:0]        sa,
  output logic [5:0]        funct,
  output logic [DATA_W-1:0] imm_ext,
  output logic [DATA_W-1:0] jump_target,
  output logic              wr_en,
  output logic [4:0]        wr_addr,
  output logic [DATA_W-1:0] pc_out
);

  typedef struct packed {
    logic [5:0]        opcode;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        sa;
    logic [5:0]        funct;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] jump_target;
    logic              wr_en;
    logic [4:0]        wr_addr;
    logic [DATA_W-1:0] pc;
  } bundle_t;

  localparam logic [DATA_W-1:0] REGION_MASK = {{(DATA_W-28){1'b1}}, 28'h0};

  bundle_t           dec;
  logic [DATA_W-1:0] pc4;
  bundle_t           main_q, main_d, skid_q, skid_d;
  logic              main_v_q, main_v_d, skid_v_q, skid_v_d;
  logic              accept;

  always_comb begin
    dec         = '0;
    dec.opcode  = in_inst[31:26];
    dec.rs      = in_inst[25:21];
    dec.rt      = in_inst[20:16];
    dec.rd      = in_inst[15:11];
    dec.sa      = in_inst[10:6];
    dec.funct   = in_inst[5:0];
    dec.pc      = in_pc;
    pc4         = in_pc + DATA_W'(4);
    // Only the region bits of pc+4 survive; the low 28 bits come from the instruction.
    dec.jump_target = (pc4 & REGION_MASK) | DATA_W'({in_inst[25:0], 2'b00});

    if (dec.opcode == 6'h0F) begin
      dec.imm_ext = DATA_W'({in_inst[15:0], 16'h0000});
    end else if ((ZEXT_LOGIC != 0) && (dec.opcode inside {6'h0C, 6'h0D, 6'h0E})) begin
      dec.imm_ext = DATA_W'(in_inst[15:0]);
    end else begin
      dec.imm_ext = {{(DATA_W-16){in_inst[15]}}, in_inst[15:0]};
    end

    if (dec.opcode == 6'h00) begin
      dec.wr_addr = dec.rd;
      dec.wr_en   = (dec.funct != 6'h08);
    end else if (dec.opcode == 6'h03) begin
      dec.wr_addr = 5'(LINK_REG);
      dec.wr_en   = 1'b1;
    end else if (dec.opcode inside {6'h02, [6'h04:6'h07], [6'h28:6'h2B]}) begin
      dec.wr_addr = '0;
      dec.wr_en   = 1'b0;
    end else begin
      dec.wr_addr = dec.rt;
      dec.wr_en   = 1'b1;
    end
    if (dec.wr_addr == 5'd0) dec.wr_en = 1'b0;
  end

  assign in_ready = rstn & ~skid_v_q;
  assign accept   = in_valid & in_ready;

  // Skid is only ever occupied while main is stalled, so it always drains into main first.
  always_comb begin
    main_d   = main_q;
    skid_d   = skid_q;
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (!main_v_q || out_ready) begin
      if (skid_v_q) begin
        main_d   = skid_q;
        main_v_d = 1'b1;
        skid_v_d = 1'b0;
      end else begin
        main_v_d = accept;
        if (accept) main_d = dec;
      end
    end else if (accept) begin
      skid_d   = dec;
      skid_v_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
    end else begin
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
    end
  end

  assign out_valid   = main_v_q;
  assign opcode      = main_q.opcode;
  assign rs          = main_q.rs;
  assign rt          = main_q.rt;
  assign rd          = main_q.rd;
  assign sa          = main_q.sa;
  assign funct       = main_q.funct;
  assign imm_ext     = main_q.imm_ext;
  assign jump_target = main_q.jump_target;
  assign wr_en       = main_q.wr_en;
  assign wr_addr     = main_q.wr_addr;
  assign pc_out      = main_q.pc;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: the driver queues expected bundles from a reference decoder,
// the monitor checks handshake signals and every presented bundle against the queue head.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rstn, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_inst, in_pc;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, sa, wr_addr;
  logic [31:0] imm_ext, jump_target, pc_out;
  logic        wr_en;

  always #5 clk = ~clk;

  decode_stage #(.DATA_W(32), .LINK_REG(31), .ZEXT_LOGIC(1)) dut (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .sa(sa), .funct(funct),
    .imm_ext(imm_ext), .jump_target(jump_target), .wr_en(wr_en), .wr_addr(wr_addr),
    .pc_out(pc_out)
  );

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, sa;
    logic [5:0]  fn;
    logic [31:0] imm, jt;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] pc;
  } bun_t;

  bun_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 0;
  bit   rst_seen = 0;

  function automatic bun_t model(input logic [31:0] inst, input logic [31:0] pc);
    bun_t        b;
    int unsigned op, imm16;
    op    = inst >> 26;
    imm16 = inst & 32'hFFFF;
    b.op  = 6'(op);
    b.rs  = 5'((inst >> 21) & 31);
    b.rt  = 5'((inst >> 16) & 31);
    b.rd  = 5'((inst >> 11) & 31);
    b.sa  = 5'((inst >> 6) & 31);
    b.fn  = 6'(inst & 63);
    b.pc  = pc;
    if (op == 15)                b.imm = imm16 * 65536;
    else if (op >= 12 && op <= 14) b.imm = imm16;
    else if (imm16 < 32768)      b.imm = imm16;
    else                         b.imm = imm16 + 32'hFFFF0000;
    b.jt = ((pc + 32'd4) & 32'hF0000000) | ((inst & 32'h03FFFFFF) * 4);
    if (op == 0) begin
      b.wa = b.rd; b.we = (b.fn != 6'h08);
    end else if (op == 3) begin
      b.wa = 5'd31; b.we = 1'b1;
    end else if (op == 2 || (op >= 4 && op <= 7) || (op >= 40 && op <= 43)) begin
      b.wa = 5'd0; b.we = 1'b0;
    end else begin
      b.wa = b.rt; b.we = 1'b1;
    end
    if (b.wa == 0) b.we = 1'b0;
    return b;
  endfunction

  // One clock cycle: drive at negedge, account for the edge's outcome after the monitor has run.
  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic ordy, input logic fl, input logic rn);
    @(negedge clk);
    in_valid = v; in_inst = inst; in_pc = pc; out_ready = ordy; flush = fl; rstn = rn;
    #2;
    if (!rstn || flush) begin
      q.delete();
      rst_seen = !rstn;
    end else begin
      rst_seen = 0;
      if (in_valid && in_ready) q.push_back(model(in_inst, in_pc));
    end
    mon_en = 1;
  endtask

  initial begin : monitor
    bun_t act, exp_b;
    logic exp_rdy;
    forever begin
      @(negedge clk);
      #1;
      if (mon_en) begin
        checks++;
        if (out_valid !== (q.size() > 0)) begin
          errors++;
          $display("FAIL out_valid: got %b want %b", out_valid, q.size() > 0);
        end
        exp_rdy = rstn && (q.size() < 2);
        checks++;
        if (in_ready !== exp_rdy) begin
          errors++;
          $display("FAIL in_ready: got %b want %b", in_ready, exp_rdy);
        end
        act = '{opcode, rs, rt, rd, sa, funct, imm_ext, jump_target, wr_en, wr_addr, pc_out};
        if (rst_seen) begin
          checks++;
          if (act !== '0) begin
            errors++;
            $display("FAIL reset_zero: got %h want 0", act);
          end
        end
        if (out_valid === 1'b1 && q.size() > 0) begin
          exp_b = q[0];
          checks++;
          if (act !== exp_b) begin
            errors++;
            $display("FAIL bundle: got op=%h rs=%0d rt=%0d rd=%0d sa=%0d fn=%h imm=%h jt=%h we=%b wa=%0d pc=%h want op=%h rs=%0d rt=%0d rd=%0d sa=%0d fn=%h imm=%h jt=%h we=%b wa=%0d pc=%h",
                     act.op, act.rs, act.rt, act.rd, act.sa, act.fn, act.imm, act.jt, act.we, act.wa, act.pc,
                     exp_b.op, exp_b.rs, exp_b.rt, exp_b.rd, exp_b.sa, exp_b.fn, exp_b.imm, exp_b.jt, exp_b.we, exp_b.wa, exp_b.pc);
          end
          if (out_ready) void'(q.pop_front());
        end
      end
    end
  end

  function automatic logic [31:0] rand_inst();
    logic [5:0]  ops [17] = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h07, 6'h08, 6'h0C,
                              6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h28, 6'h2B, 6'h2C, 6'h3F, 6'h01};
    logic [31:0] w;
    w = $urandom;
    w[31:26] = ops[$urandom_range(0, 16)];
    if ($urandom_range(0, 5) == 0) w[5:0] = 6'h08;
    if ($urandom_range(0, 7) == 0) begin w[20:16] = 5'd0; w[15:11] = 5'd0; end
    return w;
  endfunction

  initial begin
    in_valid = 0; in_inst = '0; in_pc = '0; out_ready = 0; flush = 0; rstn = 0;
    drive(0, 32'h0, 32'h0, 0, 0, 0);
    drive(0, 32'h0, 32'h0, 0, 0, 0);
    // basic decodes with downstream always ready
    drive(1, 32'h01095020, 32'h00400000, 1, 0, 1);
    drive(1, 32'h2008FFFF, 32'h00400004, 1, 0, 1);
    drive(1, 32'h3408FFFF, 32'h00400008, 1, 0, 1);
    drive(1, 32'h3C081234, 32'h0040000C, 1, 0, 1);
    drive(1, 32'h0C000010, 32'h00400000, 1, 0, 1);
    drive(1, 32'h03E00008, 32'hFFFFFFFC, 1, 0, 1);
    drive(0, 32'h0, 32'h0, 1, 0, 1);
    // stream of 4 with a 3-cycle downstream stall
    drive(1, 32'h01095020, 32'h100, 1, 0, 1);
    drive(1, 32'h2008FFFF, 32'h104, 0, 0, 1);
    drive(1, 32'h3408FFFF, 32'h108, 0, 0, 1);
    drive(1, 32'h3C081234, 32'h10C, 0, 0, 1);
    drive(1, 32'h3C081234, 32'h10C, 1, 0, 1);
    drive(0, 32'h0, 32'h0, 1, 0, 1);
    drive(0, 32'h0, 32'h0, 1, 0, 1);
    drive(0, 32'h0, 32'h0, 1, 0, 1);
    // fill main and skid, then flush with a third instruction offered
    drive(1, 32'h2009000A, 32'h200, 0, 0, 1);
    drive(1, 32'h200A000B, 32'h204, 0, 0, 1);
    drive(1, 32'h200B000C, 32'h208, 0, 1, 1);
    drive(0, 32'h0, 32'h0, 1, 0, 1);
    drive(0, 32'h0, 32'h0, 1, 0, 1);
    // reset mid-stream
    drive(1, 32'h01095020, 32'h300, 0, 0, 1);
    drive(1, 32'h2008FFFF, 32'h304, 0, 0, 0);
    drive(1, 32'h0C000010, 32'h00400000, 1, 0, 1);
    drive(0, 32'h0, 32'h0, 1, 0, 1);
    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 3) != 0, rand_inst(), $urandom, $urandom_range(0, 2) != 0,
            $urandom_range(0, 60) == 0, $urandom_range(0, 120) != 0);
    end
    for (int i = 0; i < 10; i++) drive(0, 32'h0, 32'h0, 1, 0, 1);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
